// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman sequence loader.
// Holds the default job geometry, the loader state encoding and the 2-bit base codes.
package sw_pkg;

    localparam int SW_REF_LEN = 64;
    localparam int SW_QRY_LEN = 48;
    localparam int SW_CNT_W   = 7;

    typedef enum logic [1:0] {
        LOAD_REF,
        LOAD_QRY,
        STREAM,
        WAIT_SW
    } sw_state_e;

    // Codes are simply ASCII bits [2:1]; the core only tests them for equality.
    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_G = 2'b11;

    // True only for A/C/G/T in either case: the code selects which letter must match.
    function automatic logic is_legal_base(input logic [7:0] ch);
        logic [7:0] folded;
        folded = ch & 8'hDF;
        case (ch[2:1])
            BASE_A:  return folded == 8'h41;
            BASE_C:  return folded == 8'h43;
            BASE_T:  return folded == 8'h54;
            BASE_G:  return folded == 8'h47;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sw_base_enc.sv
// Combinational ASCII-to-base-code encoder for the sequence loader.
// With SW_LOADER_CHARCHK_EN defined it also reports whether the character is a legal nucleotide.
module sw_base_enc
    import sw_pkg::*;
(
    input  logic [7:0] in_data,
    output logic [1:0] code
`ifdef SW_LOADER_CHARCHK_EN
    ,
    output logic       legal
`endif
);

    assign code = in_data[2:1];

`ifdef SW_LOADER_CHARCHK_EN
    assign legal = is_legal_base(in_data);
`else
    logic unused_bits;
    assign unused_bits = ^{in_data[7:3], in_data[0]};
`endif

endmodule

// File: rtl/sw_seq_loader.sv
// Loads one reference/query job from a host byte stream and replays it to the Smith-Waterman core.
// Optional SW_LOADER_CHARCHK_EN adds a sticky illegal-character flag on bad_char.
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int REF_LEN = SW_REF_LEN,
    parameter int QRY_LEN = SW_QRY_LEN,
    parameter int CNT_W   = SW_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       sw_valid,
    output logic [1:0] sw_data_ref,
    output logic [1:0] sw_data_query,
    input  logic       sw_finish,
    output logic       busy,
    output logic       bad_char
);

    localparam int               ADDR_W   = $clog2(REF_LEN);
    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_LEN - 1);
    localparam logic [CNT_W-1:0] QRY_LAST = CNT_W'(QRY_LEN - 1);
    localparam logic [CNT_W-1:0] QRY_END  = CNT_W'(QRY_LEN);

    sw_state_e        state_q;
    sw_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] rd_idx;
    logic             accept;
    logic [1:0]       code;
    logic [1:0]       qry_rd;
    logic             sw_valid_d;
    logic [1:0]       sw_ref_d;
    logic [1:0]       sw_qry_d;
    logic             busy_d;

    logic [1:0] ref_buf [DEPTH];
    logic [1:0] qry_buf [DEPTH];

    // Ready is a pure state decode, forced low while reset is held.
    assign in_ready = reset && (state_q == LOAD_REF || state_q == LOAD_QRY);
    assign accept   = in_valid && in_ready;

`ifdef SW_LOADER_CHARCHK_EN
    logic legal;
    logic bad_q;

    sw_base_enc u_enc (
        .in_data (in_data),
        .code    (code),
        .legal   (legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_q <= 1'b0;
        end else if (accept) begin
            // The first character of a job restarts the flag instead of accumulating.
            if (state_q == LOAD_REF && cnt_q == '0) begin
                bad_q <= !legal;
            end else if (!legal) begin
                bad_q <= 1'b1;
            end
        end
    end

    assign bad_char = bad_q;
`else
    sw_base_enc u_enc (
        .in_data (in_data),
        .code    (code)
    );

    assign bad_char = 1'b0;
`endif

    // NOTE: buffers hold no reset; every entry is written before the stream reads it.
    always_ff @(posedge clk) begin
        if (accept && state_q == LOAD_REF) begin
            ref_buf[cnt_q[ADDR_W-1:0]] <= code;
        end
        if (accept && state_q == LOAD_QRY) begin
            qry_buf[cnt_q[ADDR_W-1:0]] <= code;
        end
    end

    // Outputs are registered, so the read index runs one ahead of the presented element.
    assign rd_idx = (state_q == STREAM) ? cnt_q + 1'b1 : '0;
    assign qry_rd = (QRY_LEN == 1 && state_q == LOAD_QRY) ? code
                                                           : qry_buf[rd_idx[ADDR_W-1:0]];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sw_valid_d = 1'b0;
        busy_d     = busy;

        unique case (state_q)
            LOAD_REF: begin
                if (accept) begin
                    busy_d = 1'b1;
                    if (cnt_q == REF_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_QRY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_QRY: begin
                if (accept) begin
                    if (cnt_q == QRY_LAST) begin
                        cnt_d      = '0;
                        state_d    = STREAM;
                        sw_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (cnt_q == REF_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_SW;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    sw_valid_d = 1'b1;
                end
            end
            WAIT_SW: begin
                if (sw_finish) begin
                    state_d = LOAD_REF;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = LOAD_REF;
                cnt_d   = '0;
            end
        endcase

        sw_ref_d = sw_valid_d ? ref_buf[rd_idx[ADDR_W-1:0]] : BASE_A;
        sw_qry_d = (sw_valid_d && rd_idx < QRY_END) ? qry_rd : BASE_A;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= LOAD_REF;
            cnt_q         <= '0;
            sw_valid      <= 1'b0;
            sw_data_ref   <= BASE_A;
            sw_data_query <= BASE_A;
            busy          <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep all state changing together at the edge.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sw_valid      <= sw_valid_d;
            sw_data_ref   <= sw_ref_d;
            sw_data_query <= sw_qry_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Self-checking bench for sw_seq_loader: scoreboard of expected stream codes plus timing checks.
module tb_sw_seq_loader;

    localparam int REF_LEN = 64;
    localparam int QRY_LEN = 48;
    localparam int TOTAL   = REF_LEN + QRY_LEN;

`ifdef SW_LOADER_CHARCHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] q;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sw_valid;
    logic [1:0] sw_data_ref;
    logic [1:0] sw_data_query;
    logic       sw_finish;
    logic       busy;
    logic       bad_char;

    int   n_checks;
    int   n_fail;
    int   cyc;
    int   last_acc;
    int   start_cyc;
    int   burst_len;
    int   rdy_low;
    bit   prev_valid;
    exp_t mon_e;
    exp_t exp_q[$];

    byte  ref_chars [REF_LEN];
    byte  qry_chars [QRY_LEN];
    byte  legal_set [8];
    byte  acgt      [4];
    byte  ttga      [4];
    bit   bad_seen  [TOTAL];
    bit   busy_seen [TOTAL];

    sw_seq_loader #(
        .REF_LEN (REF_LEN),
        .QRY_LEN (QRY_LEN),
        .CNT_W   (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .sw_valid      (sw_valid),
        .sw_data_ref   (sw_data_ref),
        .sw_data_query (sw_data_query),
        .sw_finish     (sw_finish),
        .busy          (busy),
        .bad_char      (bad_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_code(input byte c);
        case (c)
            8'h41, 8'h61: return 2'b00; // A a
            8'h43, 8'h63: return 2'b01; // C c
            8'h54, 8'h74: return 2'b10; // T t
            8'h47, 8'h67: return 2'b11; // G g
            8'h4E:        return 2'b11; // N
            default:      return 2'b00;
        endcase
    endfunction

    // Stream monitor: every valid beat is popped from the scoreboard.
    always @(negedge clk) begin
        if (sw_valid) begin
            if (!prev_valid) start_cyc = cyc;
            burst_len++;
            if (exp_q.size() == 0) begin
                check("stream_extra_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sw_data_ref", sw_data_ref, mon_e.r);
                check("sw_data_query", sw_data_query, mon_e.q);
            end
        end
        prev_valid = sw_valid;
    end

    task automatic fill_pattern();
        for (int i = 0; i < REF_LEN; i++) ref_chars[i] = acgt[i % 4];
        for (int i = 0; i < QRY_LEN; i++) qry_chars[i] = ttga[i % 4];
    endtask

    task automatic fill_random();
        for (int i = 0; i < REF_LEN; i++) ref_chars[i] = legal_set[$urandom_range(0, 7)];
        for (int i = 0; i < QRY_LEN; i++) qry_chars[i] = legal_set[$urandom_range(0, 7)];
    endtask

    // Called at a negedge; returns at the negedge after the last accept (first stream cycle).
    task automatic load_job(input bit toggle, input int fin_idx);
        byte  c;
        int   waited;
        exp_t e;
        for (int k = 0; k < REF_LEN; k++) begin
            e.r = model_code(ref_chars[k]);
            e.q = (k < QRY_LEN) ? model_code(qry_chars[k]) : 2'b00;
            exp_q.push_back(e);
        end
        rdy_low   = 0;
        burst_len = 0;
        start_cyc = -1;
        for (int i = 0; i < TOTAL; i++) begin
            if (i < REF_LEN) c = ref_chars[i];
            else             c = qry_chars[i - REF_LEN];
            if (toggle) begin
                in_valid  = 1'b0;
                sw_finish = 1'b0;
                if (!in_ready) rdy_low++;
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_data   = c;
            sw_finish = (i == fin_idx);
            waited    = 0;
            while (!in_ready && waited < 20) begin
                rdy_low++;
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                check("load_ready_timeout", 0, 1);
                in_valid  = 1'b0;
                sw_finish = 1'b0;
                return;
            end
            last_acc = cyc;
            @(negedge clk);
            bad_seen[i]  = bad_char;
            busy_seen[i] = busy;
        end
        in_valid  = 1'b0;
        sw_finish = 1'b0;
    endtask

    task automatic check_stream();
        repeat (REF_LEN + 2) @(negedge clk);
        check("burst_len", burst_len, REF_LEN);
        check("stream_start", start_cyc, last_acc + 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("wait_sw_valid", sw_valid, 0);
        check("wait_in_ready", in_ready, 0);
        check("wait_busy", busy, 1);
    endtask

    task automatic pulse_finish();
        sw_finish = 1'b1;
        check("fin_cycle_in_ready", in_ready, 0);
        check("fin_cycle_busy", busy, 1);
        @(negedge clk);
        sw_finish = 1'b0;
        in_valid  = 1'b0;
        check("post_fin_in_ready", in_ready, 1);
        check("post_fin_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_hi;
        n_checks  = 0;
        n_fail    = 0;
        prev_valid = 1'b0;
        burst_len = 0;
        start_cyc = -1;
        last_acc  = 0;
        legal_set = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74};
        acgt      = '{8'h41, 8'h43, 8'h47, 8'h54};
        ttga      = '{8'h54, 8'h54, 8'h47, 8'h41};
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        sw_finish = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_sw_valid", sw_valid, 0);
        check("rst_sw_data_ref", sw_data_ref, 0);
        check("rst_sw_data_query", sw_data_query, 0);
        check("rst_busy", busy, 0);
        check("rst_bad_char", bad_char, 0);
        reset = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        @(negedge clk);

        // Job 1: fixed pattern, in_valid held high.
        fill_pattern();
        load_job(1'b0, -1);
        check("j1_busy_first", busy_seen[0], 1);
        check("j1_ready_held", rdy_low, 0);
        check_stream();

        // Host keeps offering data during WAIT_SW; nothing must be accepted.
        in_valid = 1'b1;
        in_data  = 8'h41;
        rdy_hi   = 0;
        repeat (50) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
        end
        check("wait_sw_no_ready", rdy_hi, 0);
        check("wait_sw_busy_held", busy, 1);
        pulse_finish();

        // Job 2: toggled valid, stray finish during query load.
        fill_random();
        load_job(1'b1, REF_LEN + 10);
        check("j2_ready_held", rdy_low, 0);
        check("j2_busy_after_stray_fin", busy_seen[REF_LEN + 10], 1);
        check_stream();
        pulse_finish();

        // Job 3: illegal 'N' as reference character 5.
        fill_pattern();
        ref_chars[5] = 8'h4E;
        load_job(1'b0, -1);
        check("j3_bad_before", bad_seen[4], 0);
        check("j3_bad_after_N", bad_seen[5], CHK_EN);
        check("j3_bad_sticky", bad_seen[TOTAL - 1], CHK_EN);
        check_stream();
        pulse_finish();

        // Job 4: legal job clears the flag, then reset while streaming code 30.
        fill_random();
        load_job(1'b0, -1);
        check("j4_bad_clear", bad_seen[0], 0);
        check("j4_bad_end", bad_seen[TOTAL - 1], 0);
        repeat (30) @(negedge clk);
        check("j4_stream_start", start_cyc, last_acc + 1);
        check("j4_valid_at_30", sw_valid, 1);
        reset = 1'b0;
        #1;
        check("midrst_sw_valid", sw_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bad_char", bad_char, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_hold_sw_valid", sw_valid, 0);
        check("midrst_hold_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("midrst_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Job 5: complete job after the abort.
        fill_random();
        load_job(1'b0, -1);
        check_stream();
        pulse_finish();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_seq_loader.md
# sw_seq_loader

Upstream feeder for the Smith-Waterman scoring core. Accepts one alignment job from a host byte stream: 64 reference characters, then 48 query characters, ASCII nucleotides, over a valid/ready handshake. It packs the characters into 2-bit base codes in local buffers. It then replays them to the core's `valid`/`data_ref`/`data_query` inputs in the exact burst format the core expects. It holds off the next job until the core pulses `finish`.

## Interface
Parameters:
- `REF_LEN`, 64: reference length in characters; must be ≥ `QRY_LEN`.
- `QRY_LEN`, 48: query length in characters.
- `CNT_W`, 7: counter width; must satisfy 2^`CNT_W` > `REF_LEN`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host character valid.
- `in_data`  in  8  ASCII character.
- `in_ready`  out  1  loader can accept a character.
- `sw_valid`  out  1  drives the core's `valid`.
- `sw_data_ref`  out  2  drives the core's `data_ref`.
- `sw_data_query`  out  2  drives the core's `data_query`.
- `sw_finish`  in  1  core's `finish` (one-cycle pulse).
- `busy`  out  1  high from the first accepted character until `sw_finish` is seen.
- `bad_char`  out  1  sticky illegal-character flag (see Configuration).

## Operation
- Base code is always `in_data[2:1]`: A/a=00, C/c=01, T/t=10, G/g=11. The core only compares codes for equality, so the mapping is arbitrary but fixed.
- States:
  - LOAD_REF (reset state):
    - `in_ready`=1.
    - Each accepted character is written to `ref_buf[cnt]`; `cnt`++.
    - On the accept with `cnt`=`REF_LEN`-1: clear `cnt`, go to LOAD_QRY.
  - LOAD_QRY:
    - `in_ready`=1.
    - Each accepted character is written to `qry_buf[cnt]`.
    - On the accept with `cnt`=`QRY_LEN`-1: clear `cnt`, go to STREAM.
  - STREAM:
    - `in_ready`=0.
    - Each cycle `sw_valid`=1, `sw_data_ref`=`ref_buf[cnt]`, and `sw_data_query`=`qry_buf[cnt]` if `cnt`<`QRY_LEN`, else 00.
    - `cnt`++.
    - After `REF_LEN` cycles, go to WAIT_SW.
  - WAIT_SW:
    - `in_ready`=0, `sw_valid`=0.
    - On `sw_finish`=1: go to LOAD_REF, `busy`→0.
- Accept condition is `in_valid && in_ready`. `in_ready` is a pure decode of the state; it never depends on `in_valid`.
- `sw_finish` is ignored in every state except WAIT_SW.
- `busy` is set on the first accepted character of a job.
- Core output ports (`max`, `pos_*`) are not consumed here.

## Timing
- Reset values: `in_ready`=0 while `reset`=0 and 1 in the first cycle after release. `sw_valid`=0, `sw_data_ref`=00, `sw_data_query`=00, `busy`=0, `bad_char`=0. Buffers are not cleared.
- `sw_*` outputs are registered.
- Let the last query character be accepted in cycle t:
  - `sw_valid` is high in cycles t+1 … t+`REF_LEN`.
  - Reference code k is presented in cycle t+1+k.
  - Query code k is presented in cycle t+1+k for k<`QRY_LEN`.
  - `sw_valid` is low from cycle t+1+`REF_LEN`.
- Stream is contiguous: no gaps, no backpressure.
- Load latency is 112 accepted characters. Host stalls (`in_valid`=0) simply hold state and `cnt`.
- `sw_finish` seen in cycle f: `in_ready`=1 and `busy`=0 in cycle f+1.
- `sw_finish` coincident with the last STREAM cycle is ignored. The core cannot legally produce it there.
- `reset` asserted mid-operation: immediate return to LOAD_REF with reset values. The partial job is discarded. The core is reset by its own reset.

## Configuration
- `SW_LOADER_CHARCHK_EN` defined:
  - Each accepted character is checked against {A,C,G,T,a,c,g,t}.
  - Any other value sets `bad_char`; the character is still stored with its `[2:1]` code.
  - `bad_char` clears on the first accepted character of the next job, unless that character is itself illegal.
- Undefined: no check; `bad_char` is tied 0.

## Structure
- Shared package `sw_pkg`:
  - `REF_LEN`/`QRY_LEN` defaults.
  - State enum {LOAD_REF, LOAD_QRY, STREAM, WAIT_SW}.
  - Base-code localparams.
- Sub-module `sw_base_enc`, combinational:
  - Input: `in_data[7:0]`.
  - Outputs: `code[1:0]`, plus `legal` under `SW_LOADER_CHARCHK_EN`.
- One shared `cnt` (`CNT_W` bits) serves both load and stream phases.

## Test plan
- Load "ACGT" repeated 16× as ref and "TTGA" repeated 12× as query, with `in_valid` held 1 → exactly 64 `sw_valid` cycles; `sw_data_ref` sequence 00,01,11,10…; `sw_data_query` 10,10,11,00… for 48 cycles then 00 for 16.
- Toggle `in_valid` every other cycle during load → same stream; `in_ready` stays 1; stream starts the cycle after the 112th accept.
- During WAIT_SW, hold `in_valid`=1 for 50 cycles, then pulse `sw_finish` → `in_ready`=0 throughout, 1 the cycle after the pulse; `busy` 1→0 at the same edge.
- With `SW_LOADER_CHARCHK_EN` defined, send 'N' (0x4E) as ref char 5 → `bad_char`=1 from the next cycle, stored code 11; next job with all-legal input → `bad_char`=0 after its first accept.
- Assert `reset`=0 while streaming code 30 → `sw_valid`=0 and `in_ready`=0 during reset; `in_ready`=1 after release; a full new job streams correctly.
- `sw_finish` pulsed during LOAD_QRY → ignored; `busy` stays 1; stream still occurs.
